pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
- AXI4-Lite write-only master that configures and sequences the axi_pwm block.
- After an init command it writes the prescaler, all channel periods and zero duty into axi_pwm.
- It then accepts per-channel duty targets and ramps each channel's duty toward its target, one register write per step, at a programmable step interval (soft start/stop).
- It sits between system control logic and axi_pwm's AXI4-Lite slave port.

Parameters:
- AXI_ADDR_WIDTH, 5: AXI address width.
- AXI_DATA_WIDTH, 32: AXI data width; register values are zero-extended.
- NUM_CHANNELS, 4: number of PWM channels.
- REG_WIDTH, 16: width of the period, duty and prescale values.
- INTERVAL_WIDTH, 16: width of the step-interval counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- init_start  in  1  pulse; starts the init sequence (honoured only in IDLE).
- prescale_cfg  in  REG_WIDTH  prescaler value written during init.
- period_cfg  in  NUM_CHANNELS*REG_WIDTH  per-channel period; channel i at [i*REG_WIDTH +: REG_WIDTH].
- interval  in  INTERVAL_WIDTH  a step tick occurs every interval+1 cycles.
- tgt_valid  in  1  target request valid.
- tgt_ready  out  1  target request accepted when valid && ready.
- tgt_channel  in  $clog2(NUM_CHANNELS)  channel index.
- tgt_duty  in  REG_WIDTH  target duty.
- tgt_step  in  REG_WIDTH  duty change per step; 0 = jump directly to target.
- init_done  out  1  high after the init sequence completes.
- busy  out  1  high while an AXI write is outstanding.
- ramp_active  out  NUM_CHANNELS  bit i = (cur_duty[i] != tgt[i]).
- axi_awvalid  out  1  / axi_awready  in  1  / axi_awaddr  out  AXI_ADDR_WIDTH
- axi_wvalid  out  1  / axi_wready  in  1  / axi_wdata  out  AXI_DATA_WIDTH
- axi_bvalid  in  1  / axi_bready  out  1

Behaviour:
- Address map:
  - prescaler = 0.
  - period of channel i = 2i+1.
  - duty of channel i = 2i+2.
- Reset values:
  - All outputs 0.
  - State IDLE; cur_duty, tgt and step registers 0.
  - Tick counter 0; tick_pending 0.
  - Reset is asynchronous and may abort a transaction mid-flight; no recovery handshake is performed.
- FSM states:
  - IDLE -> INIT on init_start.
  - INIT issues 1+2*NUM_CHANNELS writes in ascending address order: prescale, then period_i and duty_i = 0 for each channel.
  - INIT -> RUN after the last B handshake; init_done=1 in the same cycle.
  - RUN -> SCAN when tick_pending is set.
  - SCAN: walks channels 0..NUM_CHANNELS-1 in ascending order. Each channel with cur != tgt issues one write. After the last channel: clear tick_pending and return to RUN.
- AXI write protocol:
  - awvalid and wvalid rise together, with addr and data stable.
  - Each valid drops independently on its own handshake cycle.
  - bready is asserted from the cycle after both handshakes complete until bvalid&&bready.
  - Exactly one write outstanding at a time; busy covers the first valid assertion through the B handshake.
  - bresp is not present; every response is treated as OKAY.
- Step arithmetic (per channel):
  - If step==0: next = tgt.
  - If cur<tgt: next = min(cur+step, tgt).
  - If cur>tgt: next = max(cur-step, tgt).
  - Computed in REG_WIDTH+1 bits: no wrap-around, no overshoot.
  - cur_duty updates to next on the B handshake, not before.
- Tick counter:
  - Runs only in RUN/SCAN; counts 0..interval, then wraps and sets tick_pending.
  - interval==0 produces a tick every cycle.
  - A tick arriving while tick_pending is already set is merged; the ramp slows, with no error or queueing.
- Target interface:
  - tgt_ready = init_done; no backpressure beyond that.
  - On accept, tgt_duty is clamped to period_cfg[channel], then latched with tgt_step.
  - A new target for a channel mid-ramp takes effect from the next step. If a write for that channel is in flight, it completes with its already-computed value.
  - A target equal to cur issues no write.
- init_start outside IDLE is ignored. A second init requires reset.

Test Plan:
- Init sequence:
  - Stimulus: reset; init_start with prescale 9, periods 19/9/4/99.
  - Required: 9 writes (addr:data) 0:9, 1:19, 2:0, 3:9, 4:0, 5:4, 6:0, 7:99, 8:0; init_done rises with the 9th B handshake; tgt_ready was 0 before it.
- Ramp up:
  - Stimulus: interval=4; ch0 tgt 10, step 3.
  - Required: addr 2 receives 3, 6, 9, 10, successive writes at least 5 cycles apart; ramp_active[0] falls on the B handshake of the write of 10.
- Ramp down and clamp:
  - Stimulus 1: ch0 tgt 0, step 4. Required: writes 6, 2, 0.
  - Stimulus 2: ch2 tgt 50, step 3. Required: clamped to 4; writes to addr 6 are 3, 4.
- Concurrent channels:
  - Stimulus: ch1 tgt 5 step 5, and ch3 tgt 25 step 0, both accepted before one tick.
  - Required: in that tick, addr 4 = 5 then addr 8 = 25, in order, never overlapping.
- Slave backpressure:
  - Stimulus: awready delayed 3 cycles, wready immediate, bvalid delayed 2 cycles.
  - Required: wvalid drops after 1 cycle; awvalid and awaddr are held stable until handshake; no new write starts before the B handshake; busy is high throughout.
- Reset mid-write:
  - Stimulus: assert rst_n=0 while awvalid=1.
  - Required: all outputs are 0 asynchronously; after release, init_done=0 and IDLE is awaiting init_start.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: AXI4-Lite write-only sequencer for axi_pwm.
// Writes the init register set, then steps each channel's duty toward its target, one write per tick.

module pwm_ramp_lane #(
  parameter int W = 16
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic [W-1:0] step,
  output logic [W-1:0] nxt
);
  logic [W:0] up, dn;

  // One extra bit catches overflow going up and underflow going down.
  always_comb begin
    up  = {1'b0, cur} + {1'b0, step};
    dn  = {1'b0, cur} - {1'b0, step};
    nxt = cur;
    if (step == '0)     nxt = tgt;
    else if (cur < tgt) nxt = (up > {1'b0, tgt}) ? tgt : up[W-1:0];
    else if (cur > tgt) nxt = (dn[W] || (dn[W-1:0] < tgt)) ? tgt : dn[W-1:0];
  end
endmodule

module pwm_ramp_ctrl #(
  parameter int AXI_ADDR_WIDTH = 5,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_CHANNELS   = 4,
  parameter int REG_WIDTH      = 16,
  parameter int INTERVAL_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              init_start,
  input  logic [REG_WIDTH-1:0]              prescale_cfg,
  input  logic [NUM_CHANNELS*REG_WIDTH-1:0] period_cfg,
  input  logic [INTERVAL_WIDTH-1:0]         interval,
  input  logic                              tgt_valid,
  output logic                              tgt_ready,
  input  logic [$clog2(NUM_CHANNELS)-1:0]   tgt_channel,
  input  logic [REG_WIDTH-1:0]              tgt_duty,
  input  logic [REG_WIDTH-1:0]              tgt_step,
  output logic                              init_done,
  output logic                              busy,
  output logic [NUM_CHANNELS-1:0]           ramp_active,
  output logic                              axi_awvalid,
  input  logic                              axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]         axi_awaddr,
  output logic                              axi_wvalid,
  input  logic                              axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]         axi_wdata,
  input  logic                              axi_bvalid,
  output logic                              axi_bready
);
  localparam int CW = $clog2(NUM_CHANNELS);
  localparam int NW = 2 * NUM_CHANNELS + 1;
  localparam int IW = $clog2(NW + 1);

  typedef enum logic [1:0] {IDLE, INIT, RUN, SCAN} state_e;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]      data;
  } wr_req_t;

  state_e state_q, state_d;

  logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] period, cur_duty, tgt_r, step_r, nxt_duty;
  logic [REG_WIDTH-1:0]      tgt_clamp;
  logic [IW-1:0]             init_idx;
  logic [CW-1:0]             scan_ch;
  logic [INTERVAL_WIDTH-1:0] tick_cnt;
  logic                      tick_pending, tick_run, scan_last, scan_done;
  logic                      issue, ch_adv, init_fin, b_done, aw_nxt, w_nxt;
  wr_req_t                   init_req, scan_req, req;

  assign period    = period_cfg;
  assign tgt_ready = init_done;
  assign b_done    = axi_bvalid && axi_bready;
  assign aw_nxt    = axi_awvalid && !axi_awready;
  assign w_nxt     = axi_wvalid && !axi_wready;
  assign scan_last = (scan_ch == CW'(NUM_CHANNELS - 1));
  assign scan_done = ch_adv && scan_last;
  assign tick_run  = ((state_q == RUN) || (state_q == SCAN)) && (tick_cnt >= interval);
  assign tgt_clamp = (tgt_duty > period[tgt_channel]) ? period[tgt_channel] : tgt_duty;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
    pwm_ramp_lane #(.W(REG_WIDTH)) u_lane (
      .cur  (cur_duty[i]),
      .tgt  (tgt_r[i]),
      .step (step_r[i]),
      .nxt  (nxt_duty[i])
    );
    assign ramp_active[i] = (cur_duty[i] != tgt_r[i]);
  end

  // Init address equals the sequence index: 0 prescale, odd period, even zero duty.
  always_comb begin
    init_req.addr = AXI_ADDR_WIDTH'(init_idx);
    init_req.data = '0;
    if (init_idx == '0)   init_req.data = prescale_cfg;
    else if (init_idx[0]) init_req.data = period[CW'(init_idx[IW-1:1])];
    scan_req.addr = AXI_ADDR_WIDTH'({scan_ch, 1'b0}) + AXI_ADDR_WIDTH'(2);
    scan_req.data = nxt_duty[scan_ch];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    req      = init_req;
    ch_adv   = 1'b0;
    init_fin = 1'b0;
    case (state_q)
      IDLE: if (init_start) state_d = INIT;
      INIT: begin
        if (!busy) issue = 1'b1;
        else if (b_done && (init_idx == IW'(NW - 1))) begin
          init_fin = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: if (tick_pending) state_d = SCAN;
      SCAN: begin
        req = scan_req;
        if (!busy) begin
          if (ramp_active[scan_ch]) issue  = 1'b1;
          else                      ch_adv = 1'b1;
        end else if (b_done) begin
          ch_adv = 1'b1;
        end
        if (ch_adv && scan_last) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi_awvalid  <= 1'b0;
      axi_wvalid   <= 1'b0;
      axi_bready   <= 1'b0;
      axi_awaddr   <= '0;
      axi_wdata    <= '0;
      busy         <= 1'b0;
      init_done    <= 1'b0;
      init_idx     <= '0;
      scan_ch      <= '0;
      tick_cnt     <= '0;
      tick_pending <= 1'b0;
      cur_duty     <= '0;
      tgt_r        <= '0;
      step_r       <= '0;
    end else begin
      if (issue) begin
        axi_awvalid <= 1'b1;
        axi_wvalid  <= 1'b1;
        axi_awaddr  <= req.addr;
        axi_wdata   <= AXI_DATA_WIDTH'(req.data);
        busy        <= 1'b1;
      end else begin
        if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
        if (axi_wvalid && axi_wready)   axi_wvalid  <= 1'b0;
        if (busy && !axi_bready && !aw_nxt && !w_nxt) axi_bready <= 1'b1;
        if (b_done) begin
          axi_bready <= 1'b0;
          busy       <= 1'b0;
        end
      end
      // scan_ch still names the in-flight channel; wdata holds its computed step.
      if (b_done && (state_q == SCAN)) cur_duty[scan_ch] <= axi_wdata[REG_WIDTH-1:0];
      if (b_done && (state_q == INIT)) init_idx <= init_idx + IW'(1);
      if (init_fin) init_done <= 1'b1;
      if (ch_adv) scan_ch <= scan_last ? '0 : scan_ch + CW'(1);
      if (tgt_valid && tgt_ready) begin
        tgt_r[tgt_channel]  <= tgt_clamp;
        step_r[tgt_channel] <= tgt_step;
      end
      if ((state_q == RUN) || (state_q == SCAN))
        tick_cnt <= tick_run ? '0 : tick_cnt + INTERVAL_WIDTH'(1);
      // A fresh tick wins over the end-of-scan clear so it is not lost.
      if (tick_run)       tick_pending <= 1'b1;
      else if (scan_done) tick_pending <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: AXI slave model with programmable delays and a write log.
module tb_pwm_ramp_ctrl;
  localparam int AW = 5, DW = 32, NC = 4, RW = 16, IVW = 16;

  logic clk = 1'b0;
  logic rst_n, init_start, tgt_valid, tgt_ready, init_done, busy;
  logic [RW-1:0]    prescale_cfg, tgt_duty, tgt_step;
  logic [NC*RW-1:0] period_cfg;
  logic [IVW-1:0]   interval;
  logic [1:0]       tgt_channel;
  logic [NC-1:0]    ramp_active;
  logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [AW-1:0] axi_awaddr;
  logic [DW-1:0] axi_wdata;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0;
  int n_ovl = 0, n_busy_bad = 0;
  int aw_cnt, w_cnt, b_cnt;
  bit outstanding, prev_aw;
  int log_addr[$], log_data[$], log_cyc[$];
  int exp_init_d[9] = '{9, 19, 0, 9, 0, 4, 0, 99, 0};
  int exp_up[4]     = '{3, 6, 9, 10};
  int exp_dn[3]     = '{6, 2, 0};
  int aw_n, w_n, b_n, bad;

  pwm_ramp_ctrl dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start), .prescale_cfg(prescale_cfg),
    .period_cfg(period_cfg), .interval(interval), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_channel(tgt_channel), .tgt_duty(tgt_duty), .tgt_step(tgt_step), .init_done(init_done),
    .busy(busy), .ramp_active(ramp_active), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] outs();
    return 64'({tgt_ready, init_done, busy, ramp_active, axi_awvalid, axi_awaddr,
                axi_wvalid, axi_wdata, axi_bready});
  endfunction

  task automatic wait_wr(input int n, input string tag);
    int k = 0;
    while (log_addr.size() < n && k < 3000) begin @(negedge clk); k++; end
    chk({tag, "_wr_count"}, log_addr.size(), n);
  endtask

  task automatic wait_awv(input string tag);
    int k = 0;
    while (!axi_awvalid && k < 3000) begin @(negedge clk); k++; end
    chk({tag, "_awvalid_seen"}, axi_awvalid, 1);
  endtask

  task automatic send_tgt(input int ch, input int duty, input int step);
    chk("tgt_ready", tgt_ready, 1);
    tgt_valid = 1'b1; tgt_channel = 2'(ch); tgt_duty = RW'(duty); tgt_step = RW'(step);
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic chk_wr(input int idx, input int addr, input int data, input string tag);
    chk($sformatf("%s_addr%0d", tag, idx), log_addr[idx], addr);
    chk($sformatf("%s_data%0d", tag, idx), log_data[idx], data);
  endtask

  // Slave model: decides readies just after each edge; a logged entry handshakes at the next edge.
  initial begin
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; outstanding = 0; prev_aw = 0;
      end else begin
        if (axi_awvalid && !prev_aw) begin
          if (outstanding) n_ovl++;
          outstanding = 1;
        end
        prev_aw = axi_awvalid;
        if ((axi_awvalid || axi_wvalid || axi_bready) && !busy) n_busy_bad++;
        if (axi_awvalid) begin axi_awready = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin axi_awready = 0; aw_cnt = 0; end
        if (axi_wvalid) begin axi_wready = (w_cnt >= w_dly); w_cnt++; end
        else begin axi_wready = 0; w_cnt = 0; end
        if (axi_bready) begin axi_bvalid = (b_cnt >= b_dly); b_cnt++; end
        else begin axi_bvalid = 0; b_cnt = 0; end
        if (axi_bvalid && axi_bready) begin
          log_addr.push_back(int'(axi_awaddr));
          log_data.push_back(int'(axi_wdata));
          log_cyc.push_back(cyc);
          outstanding = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; init_start = 0; tgt_valid = 0; tgt_channel = 0; tgt_duty = 0; tgt_step = 0;
    prescale_cfg = 9; period_cfg = {16'd99, 16'd4, 16'd9, 16'd19}; interval = 4;
    #12;
    chk("reset_outputs", outs(), 0);
    @(negedge clk); rst_n = 1;
    repeat (3) @(negedge clk);
    chk("idle_no_writes", log_addr.size(), 0);

    // Init sequence
    init_start = 1; @(negedge clk); init_start = 0;
    chk("init_tgt_ready_low", tgt_ready, 0);
    wait_wr(9, "init");
    chk("init_done_before_last_b", init_done, 0);
    chk("tgt_ready_before_last_b", tgt_ready, 0);
    @(negedge clk);
    chk("init_done_after_last_b", init_done, 1);
    for (int i = 0; i < 9; i++) chk_wr(i, i, exp_init_d[i], "init");

    init_start = 1; @(negedge clk); init_start = 0;
    repeat (20) @(negedge clk);
    chk("second_init_ignored", log_addr.size(), 9);

    // Ramp up ch0 to 10 in steps of 3
    send_tgt(0, 10, 3);
    chk("ramp_active_on", ramp_active[0], 1);
    wait_wr(13, "up");
    chk("up_active_before_last_b", ramp_active[0], 1);
    @(negedge clk);
    chk("up_active_after_last_b", ramp_active[0], 0);
    for (int k = 0; k < 4; k++) begin
      chk_wr(9 + k, 2, exp_up[k], "up");
      if (k > 0) chk($sformatf("up_gap%0d", k), (log_cyc[9 + k] - log_cyc[8 + k]) >= 5, 1);
    end

    // Ramp down, then clamp ch2 to its period
    send_tgt(0, 0, 4);
    wait_wr(16, "down");
    for (int k = 0; k < 3; k++) chk_wr(13 + k, 2, exp_dn[k], "down");
    send_tgt(2, 50, 3);
    wait_wr(18, "clamp");
    chk_wr(16, 6, 3, "clamp");
    chk_wr(17, 6, 4, "clamp");

    // Two channels accepted back to back, serviced in one scan
    @(negedge clk);
    send_tgt(1, 5, 5);
    send_tgt(3, 25, 0);
    wait_wr(20, "conc");
    chk_wr(18, 4, 5, "conc");
    chk_wr(19, 8, 25, "conc");
    chk("conc_same_tick", (log_cyc[19] - log_cyc[18]) < 5, 1);
    repeat (30) @(negedge clk);
    chk("settled_no_extra_writes", log_addr.size(), 20);

    // Slave backpressure on AW and B
    aw_dly = 3; b_dly = 2;
    send_tgt(0, 7, 0);
    wait_awv("bp");
    aw_n = 0; w_n = 0; b_n = 0; bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (axi_awvalid) begin
        aw_n++;
        if (axi_awaddr != 5'd2 || axi_wdata != 32'd7) bad++;
      end
      if (axi_wvalid) w_n++;
      if (axi_bready) begin b_n++; if (axi_awvalid || axi_wvalid) bad++; end
      if ((axi_awvalid || axi_wvalid || axi_bready) && !busy) bad++;
      @(negedge clk);
    end
    chk("bp_awvalid_cycles", aw_n, 4);
    chk("bp_wvalid_cycles", w_n, 1);
    chk("bp_bready_cycles", b_n, 3);
    chk("bp_hold_violations", bad, 0);
    chk("bp_wr_count", log_addr.size(), 21);
    chk_wr(20, 2, 7, "bp");
    aw_dly = 0; b_dly = 0;

    // Reset while AW is pending
    aw_dly = 20;
    send_tgt(0, 0, 0);
    wait_awv("rstw");
    #2 rst_n = 0;
    #1 chk("async_reset_outputs", outs(), 0);
    aw_dly = 0;
    @(negedge clk); rst_n = 1;
    repeat (10) @(negedge clk);
    chk("post_reset_init_done", init_done, 0);
    chk("post_reset_tgt_ready", tgt_ready, 0);
    chk("post_reset_no_writes", log_addr.size(), 21);
    chk("post_reset_awvalid", axi_awvalid, 0);
    init_start = 1; @(negedge clk); init_start = 0;
    wait_wr(22, "reinit");
    chk_wr(21, 0, 9, "reinit");

    chk("no_overlapping_writes", n_ovl, 0);
    chk("busy_covers_activity", n_busy_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
